// File: rtl/dz_pkg.sv
// Shared constants, state encoding and row-strobe helper for the dot-matrix countdown sequencer.
package dz_pkg;

  localparam int unsigned ROW_N         = 8;
  localparam int unsigned ROW_W         = 3;
  localparam int unsigned DIGIT_W       = 3;
  localparam int unsigned SEC_DIV_DEF   = 50_000_000;
  localparam int unsigned SCAN_DIV_DEF  = 5_000;
  localparam int unsigned START_VAL_DEF = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } dz_state_e;

  // Active-low one-hot strobe for the given scan row.
  function automatic logic [ROW_N-1:0] row_strobe(input logic [ROW_W-1:0] idx);
    return ~(ROW_N'(1) << idx);
  endfunction

endpackage

// File: rtl/dz_countdown_ctrl_if.sv
// Control/display bundle between button logic, countdown sequencer and glyph renderer.
interface dz_countdown_ctrl_if;
  import dz_pkg::*;

  logic               start;
  logic               pause;
  logic               clear;
  logic [DIGIT_W-1:0] num;
  logic [ROW_W-1:0]   row_idx;
  logic [ROW_N-1:0]   row;
  logic               blank;
  logic               done;

  modport master (
    output start, pause, clear,
    input  num, row_idx, row, blank, done
  );

  modport slave (
    input  start, pause, clear,
    output num, row_idx, row, blank, done
  );

endinterface

// File: rtl/dz_tick_gen.sv
// Wrapping prescaler; tick flags the terminal count DIV-1, half_c flags count DIV/2-1.
module dz_tick_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick,
  output logic half_c
);

  localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  // Counter holds when en is low so a paused sequence resumes mid-interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

  assign tick   = (cnt == CW'(DIV - 1));
  assign half_c = (cnt == CW'(DIV / 2 - 1));

endmodule

// File: rtl/dz_countdown_ctrl.sv
// Countdown sequencer for the 8x8 dot-matrix display: digit stepping, row scan, done/blank.
// Optional DONE blink is enabled by defining DZ_DONE_BLINK_EN.
module dz_countdown_ctrl
  import dz_pkg::*;
#(
  parameter int unsigned SEC_DIV   = SEC_DIV_DEF,
  parameter int unsigned SCAN_DIV  = SCAN_DIV_DEF,
  parameter int unsigned START_VAL = START_VAL_DEF
) (
  input logic               clk,
  input logic               rst,
  dz_countdown_ctrl_if.slave bus
);

  localparam logic [DIGIT_W-1:0] START_NUM = DIGIT_W'(START_VAL);

  dz_state_e          state;
  logic [DIGIT_W-1:0] num_q;
  logic [ROW_W-1:0]   row_idx_q;
  logic [ROW_N-1:0]   row_q;
  logic               blank_q;
  logic               done_q;

  logic step_term;
  logic step_half;
  logic step_en;
  logic step_clr;
  logic step_tick;
  logic scan_tick;
  logic scan_half_unused;

  // A pause landing on the terminal count freezes the prescaler there,
  // so the pending decrement fires on the first RUN cycle after resume.
  assign step_clr  = bus.clear | bus.start;
  assign step_tick = (state == RUN) && step_term;
`ifdef DZ_DONE_BLINK_EN
  assign step_en   = ((state == RUN) && !(bus.pause && step_term)) || (state == DONE);
`else
  assign step_en   = (state == RUN) && !(bus.pause && step_term);
  logic unused_step_half;
  assign unused_step_half = step_half;
`endif

  dz_tick_gen #(.DIV(SEC_DIV)) u_step_gen (
    .clk    (clk),
    .rst    (rst),
    .en     (step_en),
    .clr    (step_clr),
    .tick   (step_term),
    .half_c (step_half)
  );

  dz_tick_gen #(.DIV(SCAN_DIV)) u_scan_gen (
    .clk    (clk),
    .rst    (rst),
    .en     (1'b1),
    .clr    (1'b0),
    .tick   (scan_tick),
    .half_c (scan_half_unused)
  );

  // Sequencer state and all display outputs; clear > start > pause > step_tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      num_q     <= START_NUM;
      row_idx_q <= '0;
      row_q     <= row_strobe(ROW_W'(0));
      blank_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (scan_tick) begin
        row_idx_q <= row_idx_q + ROW_W'(1);
        row_q     <= row_strobe(row_idx_q + ROW_W'(1));
      end

      if (bus.clear) begin
        state   <= IDLE;
        num_q   <= START_NUM;
        done_q  <= 1'b0;
        blank_q <= 1'b0;
      end else if (bus.start) begin
        state   <= RUN;
        num_q   <= START_NUM;
        done_q  <= 1'b0;
        blank_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            num_q <= START_NUM;
          end
          RUN: begin
            if (bus.pause) begin
              state <= PAUSE;
            end else if (step_tick) begin
              if (num_q == DIGIT_W'(1)) begin
                num_q  <= '0;
                state  <= DONE;
                done_q <= 1'b1;
              end else begin
                num_q <= num_q - DIGIT_W'(1);
              end
            end
          end
          PAUSE: begin
            if (bus.pause) begin
              state <= RUN;
            end
          end
          DONE: begin
            num_q  <= '0;
            done_q <= 1'b1;
`ifdef DZ_DONE_BLINK_EN
            // Half-step blink: toggle at both the mid and terminal counts.
            if (step_term || step_half) begin
              blank_q <= ~blank_q;
            end
`endif
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.num     = num_q;
  assign bus.row_idx = row_idx_q;
  assign bus.row     = row_q;
  assign bus.blank   = blank_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_dz_countdown_ctrl.sv
// Self-checking bench for dz_countdown_ctrl against a cycle-count reference model.
module tb_dz_countdown_ctrl;

  localparam int SEC_DIV   = 10;
  localparam int SCAN_DIV  = 2;
  localparam int START_VAL = 5;

  localparam int MI = 0;
  localparam int MR = 1;
  localparam int MP = 2;
  localparam int MD = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dz_countdown_ctrl_if bus();

  dz_countdown_ctrl #(
    .SEC_DIV  (SEC_DIV),
    .SCAN_DIV (SCAN_DIV),
    .START_VAL(START_VAL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: mode plus elapsed counts; digit and row are derived arithmetically.
  int m_mode;
  int m_run;
  int m_done_cyc;
  int m_scan_cyc;
  bit m_tie;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = MI; m_run = 0; m_done_cyc = 0; m_scan_cyc = 0;
    end else begin
      m_scan_cyc++;
      if (bus.clear) begin
        m_mode = MI; m_run = 0;
      end else if (bus.start) begin
        m_mode = MR; m_run = 0;
      end else begin
        case (m_mode)
          MR: begin
            m_tie = bus.pause && ((m_run % SEC_DIV) == SEC_DIV - 1);
            if (!m_tie) m_run++;
            if (bus.pause) m_mode = MP;
            else if (m_run == START_VAL * SEC_DIV) begin
              m_mode = MD; m_done_cyc = 0;
            end
          end
          MP: if (bus.pause) m_mode = MR;
          MD: m_done_cyc++;
          default: ;
        endcase
      end
    end
  end

  function automatic logic [2:0] exp_num();
    case (m_mode)
      MI:      return 3'(START_VAL);
      MR, MP:  return 3'(START_VAL - m_run / SEC_DIV);
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] exp_row_idx();
    return 3'((m_scan_cyc / SCAN_DIV) % 8);
  endfunction

  function automatic logic exp_blank();
`ifdef DZ_DONE_BLINK_EN
    if (m_mode == MD) return 1'((m_done_cyc / (SEC_DIV / 2)) % 2);
`endif
    return 1'b0;
  endfunction

  // Drive one cycle of pulses; returns 1 time unit after the sampling edge.
  task automatic cyc(input bit s, input bit p, input bit c);
    bus.start = s; bus.pause = p; bus.clear = c;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.pause = 1'b0; bus.clear = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.pause = 1'b0; bus.clear = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.num !== 3'd5) $display("FAIL reset num got %0d want 5", bus.num); else n_pass++;
    n_checks++; if (bus.row !== 8'hFE) $display("FAIL reset row got %h want fe", bus.row); else n_pass++;
    n_checks++; if (bus.row_idx !== 3'd0) $display("FAIL reset row_idx got %0d want 0", bus.row_idx); else n_pass++;
    n_checks++; if (bus.blank !== 1'b0) $display("FAIL reset blank got %b want 0", bus.blank); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL reset done got %b want 0", bus.done); else n_pass++;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_idle_scan();
    logic [2:0] ei;
    logic [7:0] er;
    for (int k = 0; k < 100; k++) begin
      cyc(0, 0, 0);
      ei = exp_row_idx();
      er = ~(8'd1 << ei);
      n_checks++; if (bus.row_idx !== ei) $display("FAIL scan row_idx k=%0d got %0d want %0d", k, bus.row_idx, ei); else n_pass++;
      n_checks++; if (bus.row !== er) $display("FAIL scan row k=%0d got %h want %h", k, bus.row, er); else n_pass++;
      n_checks++; if (bus.num !== 3'd5 || bus.done !== 1'b0)
        $display("FAIL idle num/done k=%0d got %0d/%b want 5/0", k, bus.num, bus.done); else n_pass++;
    end
  endtask

  task automatic test_countdown();
    logic [2:0] en;
    cyc(1, 0, 0);
    for (int k = 1; k <= 60; k++) begin
      cyc(0, 0, 0);
      en = (k < 50) ? 3'(5 - k / 10) : 3'd0;
      n_checks++; if (bus.num !== en) $display("FAIL countdown num t=%0d got %0d want %0d", k, bus.num, en); else n_pass++;
      n_checks++; if (bus.done !== (k >= 50)) $display("FAIL countdown done t=%0d got %b want %b", k, bus.done, k >= 50); else n_pass++;
    end
  endtask

  task automatic test_pause();
    logic [2:0] en;
    cyc(1, 0, 0);
    for (int k = 1; k <= 65; k++) begin
      cyc(0, (k == 15) || (k == 55), 0);
      en = (k < 10) ? 3'd5 : (k < 60) ? 3'd4 : 3'd3;
      n_checks++; if (bus.num !== en) $display("FAIL pause num t=%0d got %0d want %0d", k, bus.num, en); else n_pass++;
    end
  endtask

  task automatic test_pause_tie();
    logic [2:0] en;
    cyc(1, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      cyc(0, (k == 10) || (k == 14), 0);
      en = (k < 15) ? 3'd5 : 3'd4;
      n_checks++; if (bus.num !== en) $display("FAIL pause_tie num t=%0d got %0d want %0d", k, bus.num, en); else n_pass++;
    end
  endtask

  task automatic test_clear();
    cyc(1, 0, 0);
    repeat (30) cyc(0, 0, 0);
    n_checks++; if (bus.num !== 3'd2) $display("FAIL clear pre num got %0d want 2", bus.num); else n_pass++;
    cyc(0, 0, 1);
    n_checks++; if (bus.num !== 3'd5 || bus.done !== 1'b0)
      $display("FAIL clear num/done got %0d/%b want 5/0", bus.num, bus.done); else n_pass++;
    repeat (25) cyc(0, 0, 0);
    n_checks++; if (bus.num !== 3'd5) $display("FAIL clear idle num got %0d want 5", bus.num); else n_pass++;
  endtask

  task automatic test_priority();
    cyc(1, 0, 0);
    repeat (5) cyc(0, 0, 0);
    cyc(1, 1, 1);
    n_checks++; if (bus.num !== 3'd5 || bus.done !== 1'b0)
      $display("FAIL prio all3 num/done got %0d/%b want 5/0", bus.num, bus.done); else n_pass++;
    repeat (15) cyc(0, 0, 0);
    n_checks++; if (bus.num !== 3'd5) $display("FAIL prio idle num got %0d want 5", bus.num); else n_pass++;
    cyc(1, 0, 0);
    repeat (50) cyc(0, 0, 0);
    n_checks++; if (bus.num !== 3'd0 || bus.done !== 1'b1)
      $display("FAIL prio done num/done got %0d/%b want 0/1", bus.num, bus.done); else n_pass++;
    cyc(1, 1, 0);
    n_checks++; if (bus.num !== 3'd5 || bus.done !== 1'b0)
      $display("FAIL prio restart num/done got %0d/%b want 5/0", bus.num, bus.done); else n_pass++;
    for (int k = 1; k <= 10; k++) begin
      cyc(0, 0, 0);
      n_checks++; if (bus.num !== ((k < 10) ? 3'd5 : 3'd4))
        $display("FAIL prio restart step t=%0d got %0d want %0d", k, bus.num, (k < 10) ? 5 : 4); else n_pass++;
    end
  endtask

  task automatic test_blink();
    logic eb;
    cyc(1, 0, 0);
    repeat (50) cyc(0, 0, 0);
    for (int k = 1; k <= 22; k++) begin
      cyc(0, 0, 0);
`ifdef DZ_DONE_BLINK_EN
      eb = 1'((k / 5) % 2);
`else
      eb = 1'b0;
`endif
      n_checks++; if (bus.blank !== eb) $display("FAIL blink blank t=%0d got %b want %b", k, bus.blank, eb); else n_pass++;
      n_checks++; if (bus.done !== 1'b1 || bus.num !== 3'd0)
        $display("FAIL blink done/num t=%0d got %b/%0d want 1/0", k, bus.done, bus.num); else n_pass++;
    end
    cyc(0, 0, 1);
    n_checks++; if (bus.blank !== 1'b0 || bus.done !== 1'b0 || bus.num !== 3'd5)
      $display("FAIL blink clear blank/done/num got %b/%b/%0d want 0/0/5", bus.blank, bus.done, bus.num); else n_pass++;
  endtask

  task automatic test_async_reset();
    cyc(1, 0, 0);
    repeat (13) cyc(0, 0, 0);
    n_checks++; if (bus.num !== 3'd4) $display("FAIL areset pre num got %0d want 4", bus.num); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.num !== 3'd5 || bus.row !== 8'hFE || bus.row_idx !== 3'd0 || bus.done !== 1'b0 || bus.blank !== 1'b0)
      $display("FAIL areset outputs got num=%0d row=%h idx=%0d done=%b blank=%b want 5/fe/0/0/0",
               bus.num, bus.row, bus.row_idx, bus.done, bus.blank); else n_pass++;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit s, p, c;
    logic [2:0] ei;
    for (int k = 0; k < 500; k++) begin
      s = ($urandom_range(0, 99) < 3);
      p = ($urandom_range(0, 99) < 6);
      c = ($urandom_range(0, 99) < 2);
      cyc(s, p, c);
      ei = exp_row_idx();
      n_checks++; if (bus.num !== exp_num()) $display("FAIL rand num k=%0d got %0d want %0d", k, bus.num, exp_num()); else n_pass++;
      n_checks++; if (bus.done !== (m_mode == MD)) $display("FAIL rand done k=%0d got %b want %b", k, bus.done, m_mode == MD); else n_pass++;
      n_checks++; if (bus.blank !== exp_blank()) $display("FAIL rand blank k=%0d got %b want %b", k, bus.blank, exp_blank()); else n_pass++;
      n_checks++; if (bus.row_idx !== ei) $display("FAIL rand row_idx k=%0d got %0d want %0d", k, bus.row_idx, ei); else n_pass++;
      n_checks++; if (bus.row !== ~(8'd1 << ei)) $display("FAIL rand row k=%0d got %h want %h", k, bus.row, ~(8'd1 << ei)); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_countdown();
    test_pause();
    test_pause_tie();
    test_clear();
    test_priority();
    test_blink();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dz_countdown_ctrl.md
Name: dz_countdown_ctrl

Overview:
- Sequencer for the 8x8 red/green dot-matrix countdown display.
- Steps the digit from START_VAL down to 0 at a fixed prescaled rate, with start/pause/clear control.
- Generates the row-scan index and active-low row strobe consumed by the dot-matrix glyph renderer.
- Drives the renderer's num input; sits between the debounced button logic and the renderer.

Parameters:
- SEC_DIV, 50_000_000: clk cycles per countdown step. Must be ≥2.
- SCAN_DIV, 5_000: clk cycles per row-scan advance. Must be ≥2.
- START_VAL, 5: initial digit, range 1..7.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle pulse; begin or restart the countdown.
- pause  in  1  single-cycle pulse; toggle RUN/PAUSE.
- clear  in  1  single-cycle pulse; return to IDLE.
- num  out  3  digit to render.
- row_idx  out  3  current scan row, 0..7.
- row  out  8  active-low one-hot row strobe; bit row_idx is 0.
- blank  out  1  renderer must drive colr/colg to 0 while high.
- done  out  1  high while in DONE.

Behaviour:
- Reset values: num=START_VAL, row_idx=0, row=8'b1111_1110, blank=0, done=0, state=IDLE, both prescalers=0.
- Scan prescaler runs free in every state.
  - At count SCAN_DIV-1 it wraps to 0 and row_idx increments mod 8 (7→0).
  - row is registered from the next row_idx, so row and row_idx change in the same cycle.
- Step prescaler counts only in RUN.
  - Holds its value in PAUSE.
  - Is zeroed on entering RUN from IDLE/DONE and on clear.
  - Produces step_tick when it wraps at SEC_DIV-1.
- IDLE: num=START_VAL. start → RUN.
- RUN: on step_tick, num decrements.
  - If num is 1 at step_tick, next num=0 and state → DONE in the same edge.
  - pause → PAUSE.
- PAUSE: num frozen. pause → RUN, step prescaler resumes from its held value.
- DONE: num=0, done=1. start → RUN with num=START_VAL.
- First decrement occurs exactly SEC_DIV cycles after the start-sampling edge.
- clear in any state → IDLE next edge: num=START_VAL, done=0.
- Priority within one cycle: clear > start > pause > step_tick.
  - start while in RUN or PAUSE restarts: num=START_VAL, prescaler=0, state=RUN.
  - pause in IDLE or DONE is ignored.
  - step_tick coinciding with pause in RUN: pause wins; no decrement that cycle, prescaler holds at SEC_DIV-1; the decrement occurs on the first cycle after resume.
- All outputs registered; blank=0 in every state unless the optional feature is enabled.
- Reset asserted mid-count returns everything to reset values asynchronously.

Optional Feature:
- Macro DZ_DONE_BLINK_EN.
- Defined: in DONE, blank toggles every 2*SEC_DIV/4 = SEC_DIV/2 cycles (half-step period), starting at 0 on DONE entry. blank is forced 0 on leaving DONE. Uses the step prescaler, which runs in DONE only when this macro is defined.
- Undefined: blank is tied to 0 and the prescaler is idle in DONE.

Decomposition:
- Package dz_pkg holds:
  - state encoding: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3;
  - ROW_N=8 and DIGIT_W=3;
  - default SEC_DIV/SCAN_DIV constants.
- One sub-module, dz_tick_gen (parameter DIV; inputs clk, rst, en, clr; output tick), instanced twice for the step and scan prescalers.

Test Plan:
Bench parameters: SEC_DIV=10, SCAN_DIV=2, START_VAL=5.
1. Reset then idle 100 cycles → num=5, done=0, row steps FE→FD→…→7F→FE every 2 cycles, row_idx 0..7 wraps.
2. start pulse at cycle T → num=4 at T+10, 3 at T+20, … 0 at T+50, done=1 from T+50; num stays 0 thereafter.
3. start, pause at T+15, hold 40 cycles, pause again at T+55 → num=4 throughout the pause, num=3 at T+60 (5 cycles remaining on resume).
4. clear during RUN with num=2 → next edge num=5, done=0, state IDLE; a later step interval produces no decrement.
5. Simultaneous start+pause+clear in RUN → IDLE, num=5. Simultaneous start+pause in DONE → RUN, num=5, first decrement 10 cycles later.
6. With DZ_DONE_BLINK_EN: after done rises, blank toggles every 5 cycles; clear drops blank to 0 next edge. Async rst asserted mid-RUN → all outputs at reset values before the next clk edge.
